// File: rtl/note_freq_glide.sv
// Note-to-FCW control stage: accepts tracker notes, jumps or glides the phase
// accumulator FCW toward the target, and drives the voice gate. Glide is built only with NOTE_GLIDE_EN.
module note_freq_glide #(
  parameter int PHASE_WIDTH = 10,
  parameter int STEP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_active_high,
  input  logic                   tick_in,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [PHASE_WIDTH-1:0] note_fcw,
  input  logic                   note_glide,
  input  logic [STEP_WIDTH-1:0]  glide_step,
  input  logic                   note_off,
  output logic [PHASE_WIDTH-1:0] freq_control_word,
  output logic                   gate,
  output logic                   sliding
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_SLIDE
  } state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] target;
  logic                   transfer;
  logic                   jump_on_load;

  assign note_ready = (state != ST_LOAD);
  assign transfer   = note_valid && note_ready;

`ifdef NOTE_GLIDE_EN
  logic                   glide_r;
  logic [STEP_WIDTH-1:0]  step_r;
  logic                   from_idle;
  logic [PHASE_WIDTH:0]   step_ext;
  logic [PHASE_WIDTH:0]   dist;
  logic [PHASE_WIDTH-1:0] fcw_stepped;
  logic                   arrive;

  // Distance is taken one bit wider so a full-scale gap never aliases.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_ext    = {{(PHASE_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_r};
    dist        = '0;
    fcw_stepped = freq_control_word;
    if (target >= freq_control_word) begin
      dist        = {1'b0, target} - {1'b0, freq_control_word};
      fcw_stepped = freq_control_word + step_ext[PHASE_WIDTH-1:0];
    end else begin
      dist        = {1'b0, freq_control_word} - {1'b0, target};
      fcw_stepped = freq_control_word - step_ext[PHASE_WIDTH-1:0];
    end
    arrive = (dist <= step_ext);
  end

  assign jump_on_load = from_idle || !glide_r || (step_r == '0);
`else
  logic unused_glide;
  assign unused_glide = ^{tick_in, note_glide, glide_step};
  assign jump_on_load = 1'b1;
  assign sliding      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state             <= ST_IDLE;
      target            <= '0;
      freq_control_word <= '0;
      gate              <= 1'b0;
`ifdef NOTE_GLIDE_EN
      glide_r           <= 1'b0;
      step_r            <= '0;
      from_idle         <= 1'b0;
      sliding           <= 1'b0;
`endif
    end else if (transfer) begin
      // A new note always wins, including over a same-cycle release.
      state  <= ST_LOAD;
      target <= note_fcw;
`ifdef NOTE_GLIDE_EN
      glide_r   <= note_glide;
      step_r    <= glide_step;
      from_idle <= (state == ST_IDLE);
      sliding   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          gate <= 1'b1;
          if (jump_on_load) begin
            freq_control_word <= target;
            state             <= ST_HOLD;
          end else begin
            state <= ST_SLIDE;
`ifdef NOTE_GLIDE_EN
            sliding <= 1'b1;
`endif
          end
        end
        ST_HOLD: begin
          if (note_off) begin
            gate  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`ifdef NOTE_GLIDE_EN
        ST_SLIDE: begin
          if (note_off) begin
            // Release keeps the current pitch for the envelope tail.
            gate    <= 1'b0;
            sliding <= 1'b0;
            state   <= ST_IDLE;
          end else if (tick_in) begin
            if (arrive) begin
              freq_control_word <= target;
              sliding           <= 1'b0;
              state             <= ST_HOLD;
            end else begin
              freq_control_word <= fcw_stepped;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_freq_glide.sv
// Self-checking bench for note_freq_glide: table-driven cycle vectors through a
// scoreboard queue, plus hand-written async reset checks. Expectations follow NOTE_GLIDE_EN.
module tb_note_freq_glide;

  localparam int PW = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_active_high;
  logic          tick_in;
  logic          note_valid;
  logic          note_ready;
  logic [PW-1:0] note_fcw;
  logic          note_glide;
  logic [SW-1:0] glide_step;
  logic          note_off;
  logic [PW-1:0] freq_control_word;
  logic          gate;
  logic          sliding;

  note_freq_glide #(.PHASE_WIDTH(PW), .STEP_WIDTH(SW)) dut (
    .clk              (clk),
    .rst_active_high  (rst_active_high),
    .tick_in          (tick_in),
    .note_valid       (note_valid),
    .note_ready       (note_ready),
    .note_fcw         (note_fcw),
    .note_glide       (note_glide),
    .glide_step       (glide_step),
    .note_off         (note_off),
    .freq_control_word(freq_control_word),
    .gate             (gate),
    .sliding          (sliding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [PW-1:0] fcw;
    logic          glide;
    logic [SW-1:0] step;
    logic          off;
    logic          tick;
    logic [PW-1:0] e_fcw;
    logic          e_gate;
    logic          e_sliding;
    logic          e_ready;
  } vec_t;

  typedef struct {
    logic [PW-1:0] fcw;
    logic          gate;
    logic          sliding;
    logic          ready;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, actual, expected);
  endtask

  function automatic void add(input logic v, input int f, input logic g, input int s,
                              input logic o, input logic t, input int ef, input logic eg,
                              input logic es, input logic er);
    vec_t r;
    r.valid = v; r.fcw = PW'(f); r.glide = g; r.step = SW'(s); r.off = o; r.tick = t;
    r.e_fcw = PW'(ef); r.e_gate = eg; r.e_sliding = es; r.e_ready = er;
    vecs.push_back(r);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, and compare just after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    note_valid = v.valid; note_fcw = v.fcw; note_glide = v.glide;
    glide_step = v.step;  note_off = v.off; tick_in    = v.tick;
    e.fcw = v.e_fcw; e.gate = v.e_gate; e.sliding = v.e_sliding; e.ready = v.e_ready;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("fcw",     idx, 32'(freq_control_word), 32'(got.fcw));
    check("gate",    idx, 32'(gate),              32'(got.gate));
    check("sliding", idx, 32'(sliding),           32'(got.sliding));
    check("ready",   idx, 32'(note_ready),        32'(got.ready));
  endtask

  task automatic fill_table();
    //   v  fcw  gl step off tk   fcw  g  s  r
    add(0,   0, 0,   0, 0, 0,    0, 0, 0, 1);  // idle
    add(1, 200, 1,   8, 0, 0,    0, 0, 0, 0);  // accept from IDLE -> LOAD
    add(1, 999, 0,   0, 0, 0,  200, 1, 0, 1);  // offered during LOAD: ignored, jump lands
    add(0,   0, 0,   0, 0, 0,  200, 1, 0, 1);
    add(1, 100, 0,   0, 0, 0,  200, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  100, 1, 0, 1);
`ifdef NOTE_GLIDE_EN
    add(1, 130, 1,   8, 0, 0,  100, 1, 0, 0);  // upward glide
    add(0,   0, 0,   0, 0, 0,  100, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  108, 1, 1, 1);
    add(0,   0, 0,   0, 0, 0,  108, 1, 1, 1);  // no tick, no move
    add(0,   0, 0,   0, 0, 1,  116, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  124, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  130, 1, 0, 1);  // clamp to target
    add(0,   0, 0,   0, 0, 1,  130, 1, 0, 1);  // tick in HOLD
    add(1, 500, 0,   0, 0, 0,  130, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  500, 1, 0, 1);
    add(1,   0, 1, 255, 0, 0,  500, 1, 0, 0);  // downward glide, big step
    add(0,   0, 0,   0, 0, 0,  500, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  245, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,    0, 1, 0, 1);  // no wrap
    add(1, 500, 0,   0, 0, 0,    0, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  500, 1, 0, 1);
    add(1,   0, 1,   0, 0, 0,  500, 1, 0, 0);  // step 0 -> jump
    add(0,   0, 0,   0, 0, 0,    0, 1, 0, 1);
    add(1, 100, 0,   0, 0, 0,    0, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  100, 1, 0, 1);
    add(1, 130, 1,   8, 0, 0,  100, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  100, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  108, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,  116, 1, 1, 1);
    add(0,   0, 0,   0, 1, 1,  116, 0, 0, 1);  // release mid-slide
    add(0,   0, 0,   0, 0, 1,  116, 0, 0, 1);
    add(0,   0, 0,   0, 0, 1,  116, 0, 0, 1);
`else
    add(1, 130, 1,   8, 0, 0,  100, 1, 0, 0);  // glide request still jumps
    add(0,   0, 0,   0, 0, 1,  130, 1, 0, 1);
    add(0,   0, 0,   0, 0, 1,  130, 1, 0, 1);
    add(1, 500, 0,   0, 0, 0,  130, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  500, 1, 0, 1);
    add(1,   0, 1, 255, 0, 0,  500, 1, 0, 0);
    add(0,   0, 0,   0, 0, 1,    0, 1, 0, 1);
    add(1, 116, 0,   0, 0, 0,    0, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,  116, 1, 0, 1);
    add(0,   0, 0,   0, 1, 1,  116, 0, 0, 1);  // release
    add(0,   0, 0,   0, 0, 1,  116, 0, 0, 1);
`endif
    add(1, 300, 0,   0, 0, 0,  116, 0, 0, 0);  // from IDLE: gate waits for LOAD exit
    add(0,   0, 0,   0, 0, 0,  300, 1, 0, 1);
    add(1,  50, 0,   0, 1, 0,  300, 1, 0, 0);  // transfer beats note_off
    add(0,   0, 0,   0, 0, 0,   50, 1, 0, 1);
    add(1,  60, 0,   0, 0, 0,   50, 1, 0, 0);
    add(0,   0, 0,   0, 1, 0,   60, 1, 0, 1);  // note_off in LOAD ignored
`ifdef NOTE_GLIDE_EN
    add(1, 100, 1,  10, 0, 0,   60, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,   60, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,   70, 1, 1, 1);
    add(1,  40, 1,  10, 0, 1,   70, 1, 0, 0);  // transfer aborts slide, tick ignored
    add(0,   0, 0,   0, 0, 0,   70, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,   60, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,   50, 1, 1, 1);
    add(0,   0, 0,   0, 0, 1,   40, 1, 0, 1);  // d == step lands exactly
`else
    add(1,  40, 1,  10, 0, 1,   60, 1, 0, 0);
    add(0,   0, 0,   0, 0, 0,   40, 1, 0, 1);
`endif
  endtask

  initial begin
    rst_active_high = 1'b1;
    tick_in = 1'b0; note_valid = 1'b0; note_fcw = '0;
    note_glide = 1'b0; glide_step = '0; note_off = 1'b0;
    #2;
    check("rst_fcw",     0, 32'(freq_control_word), 0);
    check("rst_gate",    0, 32'(gate),              0);
    check("rst_sliding", 0, 32'(sliding),           0);
    check("rst_ready",   0, 32'(note_ready),        1);
    @(negedge clk);
    rst_active_high = 1'b0;
    @(posedge clk);
    #1;

    fill_table();
    foreach (vecs[i]) apply(vecs[i], i);

    // Reset asserted mid-slide (or mid-note when glide is compiled out).
    begin
      vec_t r;
      r.valid = 1; r.fcw = 130; r.glide = 1; r.step = 8; r.off = 0; r.tick = 0;
      r.e_fcw = 40; r.e_gate = 1; r.e_sliding = 0; r.e_ready = 0;
      apply(r, 100);
      r.valid = 0; r.tick = 0;
`ifdef NOTE_GLIDE_EN
      r.e_fcw = 40;  r.e_sliding = 1;
`else
      r.e_fcw = 130; r.e_sliding = 0;
`endif
      r.e_ready = 1;
      apply(r, 101);
      r.tick = 1;
`ifdef NOTE_GLIDE_EN
      r.e_fcw = 48;
`endif
      apply(r, 102);
    end
    tick_in = 1'b1;
    #2;
    rst_active_high = 1'b1;
    #1;
    check("arst_fcw",     1, 32'(freq_control_word), 0);
    check("arst_gate",    1, 32'(gate),              0);
    check("arst_sliding", 1, 32'(sliding),           0);
    check("arst_ready",   1, 32'(note_ready),        1);
    @(negedge clk);
    rst_active_high = 1'b0;
    tick_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_fcw",   k, 32'(freq_control_word), 0);
      check("post_rst_gate",  k, 32'(gate),              0);
      check("post_rst_ready", k, 32'(note_ready),        1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
